// File: rtl/ftf_iter_encoder_pkg.sv
// Shared constants and helpers for the iterative FTF (Fibonacci numeral system) encoder.
// Fibonacci tables are built at elaboration time.
package ftf_pkg;

  typedef logic [63:0][63:0] fib_tab_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [63:0] fib(input int unsigned k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd0;
    b = 64'd1;
    for (int unsigned i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int clog2(input logic [63:0] v);
    int r;
    r = 0;
    while (r < 64 && (64'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic fib_tab_t fib_table(input int unsigned off);
    fib_tab_t tab;
    for (int unsigned k = 0; k < 64; k++) tab[k] = fib(k + off);
    return tab;
  endfunction

  // Bit k carries weight fib(k+1); fib(k+2) is the point where bit k must be set.
  localparam fib_tab_t FIB_W = fib_table(1);
  localparam fib_tab_t FIB_T = fib_table(2);

endpackage

// File: rtl/ftf_iter_encoder_if.sv
// Valid/ready word interface of the FTF encoder: binary word in, codeword out.
interface ftf_iter_encoder_if
  import ftf_pkg::*;
#(
  parameter int N  = 37,
  parameter int DW = clog2(fib(N + 2))
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  code_out;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output code_out,
    output out_err,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  code_out,
    input  out_err,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/ftf_iter_encoder_bit_slice.sv
// One FTF code-bit decision: compares the remainder against the bit weight and the
// next Fibonacci threshold, copying the previous bit when the value is ambiguous.
module ftf_bit_slice #(
  parameter int DW = 6
) (
  input  logic [DW-1:0] r,
  input  logic [DW:0]   w_k,
  input  logic [DW:0]   t_k,
  input  logic          c_prev,
  output logic          c_k,
  output logic [DW-1:0] r_next
);

  logic [DW:0] r_ext;

  assign r_ext = {1'b0, r};

  // A slice fed w_k = 0 and t_k = all ones degenerates to a pass-through.
  always_comb begin
    if (r_ext < w_k) begin
      c_k = 1'b0;
    end else if (r_ext >= t_k) begin
      c_k = 1'b1;
    end else begin
      c_k = c_prev;
    end
    r_next = c_k ? DW'(r_ext - w_k) : r;
  end

endmodule

// File: rtl/ftf_iter_encoder.sv
// Iterative FTF encoder: resolves BPC codeword bits per clock, MSB first, through a
// chain of shared bit slices whose weights are selected by the current bit index.
module ftf_iter_encoder
  import ftf_pkg::*;
#(
  parameter  int N   = 37,
  parameter  int BPC = 4,
  localparam int DW  = clog2(fib(N + 2))
) (
  input logic               clock,
  input logic               reset,
  ftf_iter_encoder_if.slave bus
);

  localparam int CW = DW + 1;
  localparam int IW = clog2(N);
  localparam logic [CW-1:0] LIMIT = CW'(fib(N + 2));

  state_t        state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          c_prev_q, c_prev_d;
  logic [N-1:0]  code_q, code_d;
  logic          err_q, err_d;

  logic [BPC-1:0]         slice_c;
  logic [BPC-1:0]         slice_active;
  logic [BPC-1:0][IW-1:0] slice_pos;
  logic [DW-1:0]          chain_rem;
  logic                   chain_c;

  // Slice j handles bit idx-j; slices below bit 0 on the last step pass through.
  for (genvar j = 0; j < BPC; j++) begin : g_slice
    logic          active;
    logic [IW-1:0] pos;
    logic [CW-1:0] w_k;
    logic [CW-1:0] t_k;
    logic [DW-1:0] r_in;
    logic [DW-1:0] r_out;
    logic          c_in;
    logic          c_out;

    assign active = (idx_q >= IW'(j));
    assign pos    = idx_q - IW'(j);
    assign w_k    = active ? CW'(FIB_W[pos]) : '0;
    assign t_k    = active ? CW'(FIB_T[pos]) : '1;

    if (j == 0) begin : g_head
      assign r_in = rem_q;
      assign c_in = c_prev_q;
    end else begin : g_link
      assign r_in = g_slice[j-1].r_out;
      assign c_in = g_slice[j-1].c_out;
    end

    ftf_bit_slice #(.DW(DW)) u_slice (
      .r      (r_in),
      .w_k    (w_k),
      .t_k    (t_k),
      .c_prev (c_in),
      .c_k    (c_out),
      .r_next (r_out)
    );

    assign slice_c[j]      = c_out;
    assign slice_active[j] = active;
    assign slice_pos[j]    = pos;
  end

  assign chain_rem = g_slice[BPC-1].r_out;
  assign chain_c   = g_slice[BPC-1].c_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      idx_q    <= '0;
      c_prev_q <= 1'b0;
      code_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      c_prev_q <= c_prev_d;
      code_q   <= code_d;
      err_q    <= err_d;
    end
  end

  // An out-of-range word bypasses RUN and reports an all-ones codeword with err set.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    c_prev_d = c_prev_q;
    code_d   = code_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if ({1'b0, bus.in_data} >= LIMIT) begin
            err_d   = 1'b1;
            code_d  = '1;
            state_d = DONE;
          end else begin
            rem_d    = bus.in_data;
            idx_d    = IW'(N - 1);
            c_prev_d = 1'b0;
            code_d   = '0;
            err_d    = 1'b0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        rem_d    = chain_rem;
        c_prev_d = chain_c;
        for (int j = 0; j < BPC; j++) begin
          if (slice_active[j]) code_d[slice_pos[j]] = slice_c[j];
        end
        if ({1'b0, idx_q} < (IW + 1)'(BPC)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(BPC);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.code_out  = code_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_ftf_iter_encoder.sv
// Scoreboard bench for ftf_iter_encoder at N=8, BPC=3: the driver queues hand-computed
// codewords, an independent monitor checks every completed output handshake.
module tb_ftf_iter_encoder;
  import ftf_pkg::*;

  localparam int N   = 8;
  localparam int BPC = 3;
  localparam int DW  = clog2(fib(N + 2));
  localparam int S   = (N + BPC - 1) / BPC;

  typedef struct {
    logic [N-1:0] code;
    logic         err;
    int           lat;
    int           accept_cycle;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cycle_cnt = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  exp_t exp_q[$];
  bit   valid_seen;
  int   rise_cycle;

  ftf_iter_encoder_if #(.N(N), .DW(DW)) bus ();

  ftf_iter_encoder #(.N(N), .BPC(BPC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycle_cnt);
  endtask

  task automatic waitIdle();
    int guard = 0;
    @(negedge clock);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.in_ready) reportTimeout("wait_in_ready");
  endtask

  task automatic waitValid();
    int guard = 0;
    @(negedge clock);
    while (!bus.out_valid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.out_valid) reportTimeout("wait_out_valid");
  endtask

  // lat counts edges after the accepting edge until out_valid is seen.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic [N-1:0] code,
                               input logic err, input int lat);
    waitIdle();
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    exp_q.push_back('{code, err, lat, cycle_cnt});
    checkOutput("in_ready_after_accept", bus.in_ready, 0);
  endtask

  initial begin : monitor
    exp_t e;
    valid_seen = 1'b0;
    rise_cycle = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        valid_seen = 1'b0;
      end else if (bus.out_valid) begin
        if (!valid_seen) begin
          valid_seen = 1'b1;
          rise_cycle = cycle_cnt;
        end
        if (bus.out_ready) begin
          valid_seen = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_output: got code 0x%0h, required no output", bus.code_out);
          end else begin
            e = exp_q.pop_front();
            checkOutput("code_out", bus.code_out, e.code);
            checkOutput("out_err", bus.out_err, e.err);
            checkOutput("latency", rise_cycle - e.accept_cycle, e.lat);
          end
        end
      end
    end
  end

  initial begin : driver
    int guard;
    reset         = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_code_out", bus.code_out, 0);
    checkOutput("reset_out_err", bus.out_err, 0);

    applyStimulus(6'd0,  8'h00, 1'b0, S);
    applyStimulus(6'd54, 8'hFF, 1'b0, S);
    applyStimulus(6'd21, 8'h60, 1'b0, S);
    applyStimulus(6'd13, 8'h30, 1'b0, S);

    // Sink stalls on 33; a word offered meanwhile must be ignored.
    waitIdle();
    bus.out_ready = 1'b0;
    applyStimulus(6'd33, 8'h7F, 1'b0, S);
    waitValid();
    bus.in_data  = 6'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_code_out", bus.code_out, 8'h7F);
      checkOutput("hold_out_valid", bus.out_valid, 1);
      checkOutput("hold_in_ready", bus.in_ready, 0);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1 bus.out_ready = 1'b1;

    // Out-of-range word reaches DONE on the accepting edge itself.
    applyStimulus(6'd55, 8'hFF, 1'b1, 0);

    // Reset in the second RUN cycle discards the partial word.
    waitIdle();
    bus.in_data  = 6'd33;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_out_valid", bus.out_valid, 0);
    checkOutput("async_reset_code_out", bus.code_out, 0);
    checkOutput("async_reset_out_err", bus.out_err, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_in_ready", bus.in_ready, 1);
    checkOutput("post_reset_out_valid", bus.out_valid, 0);

    applyStimulus(6'd54, 8'hFF, 1'b0, S);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    repeat (3) @(negedge clock);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
